// File: rtl/stateful_app_state_alu_if.sv
// Request/response bundle for the stateful ALU stage.
// master drives requests and consumes results; slave is the ALU stage.
interface stateful_app_state_alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [1:0]            in_op;
    logic [DATA_WIDTH-1:0] in_operand;
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_old;
    logic [DATA_WIDTH-1:0] out_new;

    modport master (
        output in_valid, in_addr, in_op, in_operand,
        input  in_ready, out_valid, out_addr, out_old, out_new
    );

    modport slave (
        input  in_valid, in_addr, in_op, in_operand,
        output in_ready, out_valid, out_addr, out_old, out_new
    );
endinterface

// File: rtl/stateful_app_state_alu.sv
// Read-modify-write state table stage: 2-cycle latency, one request per cycle,
// write-result forwarding. Define STATEFUL_ALU_SATURATE_EN for saturating ADD.
module stateful_app_state_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    stateful_app_state_alu_if.slave  io_bus
);
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] f_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef STATEFUL_ALU_SATURATE_EN
        return sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
`else
        return sum[DATA_WIDTH-1:0];
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_alu(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] operand
    );
        logic [DATA_WIDTH-1:0] res;
        case (op)
            OP_ADD:  res = f_add(old_val, operand);
            OP_SET:  res = operand;
            OP_MAX:  res = (operand > old_val) ? operand : old_val;
            default: res = old_val;
        endcase
        return res;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  w_ready;
    logic                  w_init_wr;
    logic                  w_accept;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  r_vld_p1;
    logic [ADDR_WIDTH-1:0] r_addr_p1;
    logic [1:0]            r_op_p1;
    logic [DATA_WIDTH-1:0] r_operand_p1;
    logic [DATA_WIDTH-1:0] r_rd_data_p1;

    logic                  w_hit_p1;
    logic [DATA_WIDTH-1:0] w_old_p1;
    logic [DATA_WIDTH-1:0] w_new_p1;
    logic                  w_wr_p1;

    logic                  r_fwd_vld;
    logic [ADDR_WIDTH-1:0] r_fwd_addr;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    logic                  r_vld_p2;
    logic [ADDR_WIDTH-1:0] r_addr_p2;
    logic [DATA_WIDTH-1:0] r_old_p2;
    logic [DATA_WIDTH-1:0] r_new_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_cnt == {ADDR_WIDTH{1'b1}}) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_ready   = 1'b0;
        w_init_wr = 1'b0;
        case (r_state)
            ST_INIT: w_init_wr = 1'b1;
            default: w_ready   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_init_cnt <= '0;
        else if (w_init_wr) r_init_cnt <= r_init_cnt + 1'b1;
    end

    assign w_accept        = io_bus.in_valid & w_ready;
    assign io_bus.in_ready = w_ready;

    // Table storage has no reset; INIT zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (w_init_wr)    r_mem[r_init_cnt] <= '0;
        else if (w_wr_p1) r_mem[r_addr_p1]  <= w_new_p1;
    end

    // S0 -> S1: synchronous table read and request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1     <= 1'b0;
            r_addr_p1    <= '0;
            r_op_p1      <= OP_NOP;
            r_operand_p1 <= '0;
            r_rd_data_p1 <= '0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_addr_p1    <= io_bus.in_addr;
                r_op_p1      <= io_bus.in_op;
                r_operand_p1 <= io_bus.in_operand;
                r_rd_data_p1 <= r_mem[io_bus.in_addr];
            end
        end
    end

    // The RAM read above misses a write landing on the same edge; the
    // forwarding register holds exactly that write.
    assign w_hit_p1 = r_fwd_vld && (r_fwd_addr == r_addr_p1);
    assign w_old_p1 = w_hit_p1 ? r_fwd_data : r_rd_data_p1;
    assign w_new_p1 = f_alu(r_op_p1, w_old_p1, r_operand_p1);
    assign w_wr_p1  = r_vld_p1 && (r_op_p1 != OP_NOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd_vld  <= 1'b0;
            r_fwd_addr <= '0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_vld <= w_wr_p1;
            if (w_wr_p1) begin
                r_fwd_addr <= r_addr_p1;
                r_fwd_data <= w_new_p1;
            end
        end
    end

    // S1 -> S2: result registers; data holds while no result is emitted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p2  <= 1'b0;
            r_addr_p2 <= '0;
            r_old_p2  <= '0;
            r_new_p2  <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_addr_p2 <= r_addr_p1;
                r_old_p2  <= w_old_p1;
                r_new_p2  <= w_new_p1;
            end
        end
    end

    assign io_bus.out_valid = r_vld_p2;
    assign io_bus.out_addr  = r_addr_p2;
    assign io_bus.out_old   = r_old_p2;
    assign io_bus.out_new   = r_new_p2;
endmodule

// File: tb/tb_stateful_app_state_alu.sv
// Scoreboard bench for stateful_app_state_alu: directed requests push expected
// results; a negedge monitor pops and compares every out_valid pulse.
module tb_stateful_app_state_alu;
    localparam int DW = 32;
    localparam int AW = 8;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SET = 2'b10;
    localparam logic [1:0] MAX = 2'b11;

`ifdef STATEFUL_ALU_SATURATE_EN
    localparam logic [DW-1:0] OVF_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [DW-1:0] OVF_EXP = 32'h0000_0003;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] old_v;
        logic [DW-1:0] new_v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    stateful_app_state_alu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    stateful_app_state_alu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: addr %h old %h new %h with nothing outstanding",
                             bus.out_addr, bus.out_old, bus.out_new);
                end else begin
                    e = q.pop_front();
                    if (bus.out_valid !== 1'b1 || bus.out_addr !== e.addr ||
                        bus.out_old !== e.old_v || bus.out_new !== e.new_v) begin
                        n_err++;
                        $display("FAIL result: got addr %h old %h new %h, want addr %h old %h new %h",
                                 bus.out_addr, bus.out_old, bus.out_new, e.addr, e.old_v, e.new_v);
                    end
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [1:0] op, input logic [DW-1:0] opnd,
                        input logic [DW-1:0] exp_old, input logic [DW-1:0] exp_new);
        bus.in_valid   = 1'b1;
        bus.in_addr    = a;
        bus.in_op      = op;
        bus.in_operand = opnd;
        q.push_back('{addr: a, old_v: exp_old, new_v: exp_new});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_and_init(input logic hold_valid);
        int bad;
        reset        = 1'b1;
        bus.in_valid = hold_valid;
        bus.in_addr  = 8'd5;
        bus.in_op    = ADD;
        bus.in_operand = 32'd7;
        #1;
        check("rst_out_valid_async", {31'd0, bus.out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_new", bus.out_new, 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) bad++;
        end
        check("init_ready_low_cycles", bad, 32'd0);
        @(negedge clk);
        check("init_ready_high", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_addr    = '0;
        bus.in_op      = NOP;
        bus.in_operand = '0;

        // Init with in_valid held high: nothing may be accepted or emitted.
        reset_and_init(1'b1);
        send(8'd5, NOP, 32'd0, 32'd0, 32'd0);
        idle(3);

        // Back-to-back same-address ADDs exercise forwarding.
        for (int i = 0; i < 4; i++)
            send(8'd3, ADD, 32'd1, DW'(i), DW'(i + 1));
        idle(3);

        // Mixed ops with a one-cycle gap.
        send(8'd7, SET, 32'd10, 32'd0, 32'd10);               idle(1);
        send(8'd7, MAX, 32'd4, 32'd10, 32'd10);               idle(1);
        send(8'd7, MAX, 32'hFFFF_0000, 32'd10, 32'hFFFF_0000); idle(1);
        send(8'd7, NOP, 32'd0, 32'hFFFF_0000, 32'hFFFF_0000); idle(3);

        // Overflow, back-to-back.
        send(8'd1, SET, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFE);
        send(8'd1, ADD, 32'd5, 32'hFFFF_FFFE, OVF_EXP);
        idle(3);

        // Interleaved addresses must not forward across entries.
        send(8'd9,  ADD, 32'd1, 32'd0, 32'd1);
        send(8'd10, ADD, 32'd1, 32'd0, 32'd1);
        send(8'd9,  ADD, 32'd1, 32'd1, 32'd2);
        send(8'd10, ADD, 32'd1, 32'd1, 32'd2);
        idle(3);

        // A NOP in the middle leaves no forward; the RAM must supply the SET.
        send(8'd20, SET, 32'd100, 32'd0, 32'd100);
        send(8'd20, NOP, 32'd0, 32'd100, 32'd100);
        send(8'd20, ADD, 32'd1, 32'd100, 32'd101);
        send(8'd20, MAX, 32'd50, 32'd101, 32'd101);
        idle(3);

        // Reset with a request in flight: no pulse, table re-zeroed.
        send(8'd2, SET, 32'd55, 32'd0, 32'd55);
        idle(3);
        bus.in_valid   = 1'b1;
        bus.in_addr    = 8'd2;
        bus.in_op      = ADD;
        bus.in_operand = 32'd1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset_and_init(1'b0);
        send(8'd2, NOP, 32'd0, 32'd0, 32'd0);
        send(8'd3, NOP, 32'd0, 32'd0, 32'd0);
        idle(5);

        check("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
